rtc_timekeeper: RTL and testbench

- BCD real-time-clock core downstream of the 64-bit data register written over SPI by the SPI controller.
- Takes a full 64-bit time/control image on a load strobe and counts seconds from the system clock.
- Presents the live 64-bit image back to the SPI controller's read buffer, in the same layout.

---
 rtl/rtc_timekeeper.sv | 120 ++++++++++++
 tb/tb_rtc_timekeeper.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_timekeeper.sv
// BCD real-time-clock core: loads a 64-bit time/control image, counts seconds off the system clock.
// Optional alarm comparator enabled by defining RTC_ALARM_EN.
module rtc_timekeeper #(
    parameter int unsigned CLK_HZ = 53200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] load_time,
    output logic [63:0] time_q,
    output logic        tick_1hz,
    input  logic        alarm_we,
    input  logic [23:0] alarm_d,
    input  logic        alarm_ack,
    output logic        alarm_irq
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] TC = PW'(CLK_HZ - 1);
    localparam logic [63:0] RESET_IMG = 64'h0000_0101_0100_0000;

    logic [PW-1:0] presc_q, presc_d;
    logic          run, term, tick_q;
    logic [63:0]   time_inc, load_img;
    logic [7:0]    date_lim;
    logic [4:0]    year_sum;
    logic          leap;
    logic [8:0]    r_sec, r_min, r_hr, r_dow, r_date, r_mon, r_yr;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] >= 4'h9) return {v[7:4] + 4'h1, 4'h0};
        return {v[7:4], v[3:0] + 4'h1};
    endfunction

    // Returns {carry_out, new_value}; a disabled field passes through unchanged.
    function automatic logic [8:0] fstep(input logic [7:0] v, input logic en,
                                         input logic [7:0] lim, input logic [7:0] base);
        if (!en) return {1'b0, v};
        if (v >= lim) return {1'b1, base};
        return {1'b0, bcd_inc(v)};
    endfunction

    assign run      = time_q[56];
    assign term     = run && (presc_q == TC);
    assign load_img = {6'b0, 1'b1, load_time[56:0]};

    // Year mod 4 from BCD digits: 10*t + o == 2*t + o (mod 4).
    assign year_sum = {time_q[55:52], 1'b0} + {1'b0, time_q[51:48]};
    assign leap     = (year_sum[1:0] == 2'b00);

    always_comb begin
        date_lim = 8'h31;
        case (time_q[47:40])
            8'h04, 8'h06, 8'h09, 8'h11: date_lim = 8'h30;
            8'h02:                      date_lim = leap ? 8'h29 : 8'h28;
            default:                    date_lim = 8'h31;
        endcase
    end

    assign r_sec  = fstep(time_q[7:0],   1'b1,      8'h59, 8'h00);
    assign r_min  = fstep(time_q[15:8],  r_sec[8],  8'h59, 8'h00);
    assign r_hr   = fstep(time_q[23:16], r_min[8],  8'h23, 8'h00);
    assign r_dow  = fstep(time_q[31:24], r_hr[8],   8'h07, 8'h01);
    assign r_date = fstep(time_q[39:32], r_hr[8],   date_lim, 8'h01);
    assign r_mon  = fstep(time_q[47:40], r_date[8], 8'h12, 8'h01);
    assign r_yr   = fstep(time_q[55:48], r_mon[8],  8'h99, 8'h00);

    assign time_inc = {time_q[63:56], r_yr[7:0], r_mon[7:0], r_date[7:0], r_dow[7:0],
                       r_hr[7:0], r_min[7:0], r_sec[7:0]};

    always_comb begin
        presc_d = '0;
        if (run && !term) presc_d = presc_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q  <= RESET_IMG;
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else if (load) begin
            time_q  <= load_img;
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= term;
            if (term) time_q <= time_inc;
        end
    end

    assign tick_1hz = tick_q;

`ifdef RTC_ALARM_EN
    logic [23:0] alarm_q;
    logic        irq_q;
    logic        unused_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            if (alarm_we) alarm_q <= alarm_d;
            // A match on the same edge as an ack keeps the flag set.
            if (term && !load && (time_inc[23:0] == alarm_q)) irq_q <= 1'b1;
            else if (alarm_ack) irq_q <= 1'b0;
        end
    end

    assign alarm_irq   = irq_q;
    assign unused_bits = ^{load_time[63:57], r_dow[8], r_yr[8]};
`else
    logic unused_bits;

    assign alarm_irq   = 1'b0;
    assign unused_bits = ^{load_time[63:57], r_dow[8], r_yr[8], alarm_we, alarm_d, alarm_ack};
`endif

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper: directed corner cases plus randomized loads checked
// against a calendar-arithmetic reference model.
module tb_rtc_timekeeper;

    localparam int unsigned CLK_HZ = 4;
    localparam logic [63:0] RESET_IMG = 64'h0000_0101_0100_0000;

    logic        clk = 1'b0;
    logic        rst, load, alarm_we, alarm_ack;
    logic [63:0] load_time;
    logic [23:0] alarm_d;
    logic [63:0] time_q;
    logic        tick_1hz, alarm_irq;

    int vectors = 0;
    int miscompares = 0;

    int m_sec, m_min, m_hr, m_dow, m_date, m_mon, m_yr;
    bit m_run;

    rtc_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_time (load_time),
        .time_q    (time_q),
        .tick_1hz  (tick_1hz),
        .alarm_we  (alarm_we),
        .alarm_d   (alarm_d),
        .alarm_ack (alarm_ack),
        .alarm_irq (alarm_irq)
    );

    always #5 clk = ~clk;

    function automatic int bcd2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] i2bcd(input int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    function automatic int dim(input int mo, input int yr);
        case (mo)
            4, 6, 9, 11: return 30;
            2:           return (yr % 4 == 0) ? 29 : 28;
            default:     return 31;
        endcase
    endfunction

    function automatic logic [63:0] model_img();
        return {6'b0, 1'b1, m_run, i2bcd(m_yr), i2bcd(m_mon), i2bcd(m_date), i2bcd(m_dow),
                i2bcd(m_hr), i2bcd(m_min), i2bcd(m_sec)};
    endfunction

    task automatic model_load(input logic [63:0] img);
        m_run  = img[56];
        m_yr   = bcd2i(img[55:48]);
        m_mon  = bcd2i(img[47:40]);
        m_date = bcd2i(img[39:32]);
        m_dow  = bcd2i(img[31:24]);
        m_hr   = bcd2i(img[23:16]);
        m_min  = bcd2i(img[15:8]);
        m_sec  = bcd2i(img[7:0]);
    endtask

    task automatic model_tick();
        m_sec++;
        if (m_sec == 60) begin
            m_sec = 0;
            m_min++;
            if (m_min == 60) begin
                m_min = 0;
                m_hr++;
                if (m_hr == 24) begin
                    m_hr  = 0;
                    m_dow = m_dow % 7 + 1;
                    m_date++;
                    if (m_date > dim(m_mon, m_yr)) begin
                        m_date = 1;
                        m_mon++;
                        if (m_mon == 13) begin
                            m_mon = 1;
                            m_yr  = (m_yr + 1) % 100;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [63:0] img);
        @(negedge clk);
        load      = 1'b1;
        load_time = img;
        @(negedge clk);
        load = 1'b0;
        model_load(img);
    endtask

    // Expects silence for CLK_HZ-1 cycles, then a tick on the CLK_HZ-th.
    task automatic await_tick(input string tag);
        repeat (CLK_HZ - 1) begin
            @(negedge clk);
            check({tag, " early"}, {63'b0, tick_1hz}, 64'd0);
        end
        @(negedge clk);
        check({tag, " tick"}, {63'b0, tick_1hz}, 64'd1);
    endtask

    task automatic tick_and_model(input string tag);
        await_tick(tag);
        model_tick();
        check({tag, " time"}, time_q, model_img());
    endtask

    initial begin
        logic [63:0] img;
        int yr, mo, dt, hr, mn, sc, dw;

        rst = 1'b1; load = 1'b0; load_time = '0;
        alarm_we = 1'b0; alarm_d = '0; alarm_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst time", time_q, RESET_IMG);
        check("rst tick", {63'b0, tick_1hz}, 64'd0);
        check("rst irq", {63'b0, alarm_irq}, 64'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("idle time", time_q, RESET_IMG);

        do_load(64'h0100_0101_0100_0000);
        check("load1 img", time_q, 64'h0300_0101_0100_0000);
        check("load1 tick", {63'b0, tick_1hz}, 64'd0);
        tick_and_model("first");
        check("first const", time_q, 64'h0300_0101_0100_0001);

        do_load(64'h0199_1231_0723_5959);
        tick_and_model("rollover");
        check("rollover const", time_q, 64'h0300_0101_0100_0000);

        do_load(64'h0124_0228_0323_5959);
        tick_and_model("leap24");
        check("leap24 const", time_q, 64'h0324_0229_0400_0000);
        do_load(64'h0123_0228_0323_5959);
        tick_and_model("nonleap23");
        check("nonleap23 const", time_q, 64'h0323_0301_0400_0000);
        do_load(64'h0124_0229_0423_5959);
        tick_and_model("leap24 feb29");
        do_load(64'h0100_0228_0623_5959);
        tick_and_model("leap00");
        do_load(64'h0150_0430_0223_5959);
        tick_and_model("apr30");

        // Load lands on the terminal-count edge: the tick is discarded.
        do_load(64'h0105_0615_0212_3456);
        repeat (2) @(negedge clk);
        do_load(64'h0107_0820_0511_1111);
        check("coinc tick", {63'b0, tick_1hz}, 64'd0);
        check("coinc img", time_q, 64'h0307_0820_0511_1111);
        tick_and_model("coinc next");

        do_load(64'h0100_0101_0100_007A);
        await_tick("oor sec");
        check("oor sec time", time_q, 64'h0300_0101_0100_0100);
        do_load(64'h0100_0101_0105_6059);
        await_tick("oor min");
        check("oor min time", time_q, 64'h0300_0101_0106_0000);
        do_load(64'h0105_1331_0123_5959);
        await_tick("oor mon");
        check("oor mon time", time_q, 64'h0306_0101_0200_0000);

        for (int i = 0; i < 24; i++) begin
            yr = $urandom_range(0, 99);
            mo = $urandom_range(1, 12);
            dt = ($urandom_range(0, 1) == 1) ? dim(mo, yr) : $urandom_range(1, dim(mo, yr));
            hr = ($urandom_range(0, 1) == 1) ? 23 : $urandom_range(0, 23);
            mn = ($urandom_range(0, 1) == 1) ? 59 : $urandom_range(0, 59);
            sc = ($urandom_range(0, 2) != 0) ? 59 : $urandom_range(0, 59);
            dw = $urandom_range(1, 7);
            if (i % 6 == 0) begin
                mo = 12;
                dt = 31;
            end
            img = {8'h01, i2bcd(yr), i2bcd(mo), i2bcd(dt), i2bcd(dw), i2bcd(hr), i2bcd(mn),
                   i2bcd(sc)};
            do_load(img);
            check("rand load", time_q, model_img());
            repeat ($urandom_range(1, 3)) tick_and_model("rand");
        end

        do_load(64'h0012_0304_0508_0910);
        check("stop img", time_q, 64'h0212_0304_0508_0910);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stop tick", {63'b0, tick_1hz}, 64'd0);
        end
        check("stop hold", time_q, 64'h0212_0304_0508_0910);
        do_load(64'h0112_0304_0508_0910);
        tick_and_model("restart");

        do_load(64'h0100_0101_0100_0000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("async rst time", time_q, RESET_IMG);
        check("async rst tick", {63'b0, tick_1hz}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post rst tick", {63'b0, tick_1hz}, 64'd0);
        end
        check("post rst time", time_q, RESET_IMG);

`ifdef RTC_ALARM_EN
        @(negedge clk);
        alarm_we = 1'b1;
        alarm_d  = 24'h00_00_02;
        @(negedge clk);
        alarm_we = 1'b0;
        do_load(64'h0100_0101_0100_0000);
        tick_and_model("alarm t1");
        check("alarm t1 irq", {63'b0, alarm_irq}, 64'd0);
        tick_and_model("alarm t2");
        check("alarm t2 irq", {63'b0, alarm_irq}, 64'd1);
        @(negedge clk);
        check("alarm sticky", {63'b0, alarm_irq}, 64'd1);
        alarm_ack = 1'b1;
        @(negedge clk);
        alarm_ack = 1'b0;
        check("alarm ack", {63'b0, alarm_irq}, 64'd0);
`else
        alarm_we  = 1'b1;
        alarm_d   = 24'h00_00_01;
        alarm_ack = 1'b1;
        do_load(64'h0100_0101_0100_0000);
        tick_and_model("noalarm");
        check("noalarm irq", {63'b0, alarm_irq}, 64'd0);
        alarm_we  = 1'b0;
        alarm_ack = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
